// File: rtl/pipe_ctl_pkg.sv
// Shared constants for the pipeline stall/flush/redirect sequencer:
// FSM state encodings, exception vector indices and the vector address helper.
package pipe_ctl_pkg;

  localparam logic [1:0] PIPECTL_RUN    = 2'd0;
  localparam logic [1:0] PIPECTL_REDIR  = 2'd1;
  localparam logic [1:0] PIPECTL_SHADOW = 2'd2;

  typedef enum logic [1:0] {
    StRun    = PIPECTL_RUN,
    StRedir  = PIPECTL_REDIR,
    StShadow = PIPECTL_SHADOW
  } pipe_state_e;

  // Exception vector indices; index 5 is reserved.
  localparam logic [2:0] EXC_RESET  = 3'd0;
  localparam logic [2:0] EXC_UNDEF  = 3'd1;
  localparam logic [2:0] EXC_SWI    = 3'd2;
  localparam logic [2:0] EXC_PABORT = 3'd3;
  localparam logic [2:0] EXC_DABORT = 3'd4;
  localparam logic [2:0] EXC_IRQ    = 3'd6;
  localparam logic [2:0] EXC_FIQ    = 3'd7;

  localparam int unsigned CntWidth = 3;

  // Vector entries are one word apart; the sum wraps at 32 bits.
  function automatic logic [31:0] exc_target(input logic [31:0] base, input logic [2:0] vec);
    return base + {27'd0, vec, 2'b00};
  endfunction

endpackage

// File: rtl/pipe_ctl_if.sv
// Handshake bundle between the pipeline sequencer (master) and the pipeline stages (slave).
// Perf counter outputs exist only when PIPE_CTL_PERF_EN is defined.
interface pipe_ctl_if;

  logic        mem_busy;
  logic        issue_outstall;
  logic        jmp_valid;
  logic [31:0] jmp_pc;
  logic        exc_req;
  logic [2:0]  exc_vec;
  logic        fetch_ack;

  logic        stall_fetch;
  logic        stall_issue;
  logic        stall_exec;
  logic        flush_fetch;
  logic        flush_issue;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_taken;
`ifdef PIPE_CTL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
`endif

  modport master (
    input  mem_busy, issue_outstall, jmp_valid, jmp_pc, exc_req, exc_vec, fetch_ack,
    output stall_fetch, stall_issue, stall_exec, flush_fetch, flush_issue,
           redirect_valid, redirect_pc, exc_taken
`ifdef PIPE_CTL_PERF_EN
    , output perf_stall_cycles, perf_redirects
`endif
  );

  modport slave (
    output mem_busy, issue_outstall, jmp_valid, jmp_pc, exc_req, exc_vec, fetch_ack,
    input  stall_fetch, stall_issue, stall_exec, flush_fetch, flush_issue,
           redirect_valid, redirect_pc, exc_taken
`ifdef PIPE_CTL_PERF_EN
    , input perf_stall_cycles, perf_redirects
`endif
  );

endinterface

// File: rtl/pipe_ctl_target.sv
// Redirect target mux: an exception outranks a jump and selects its vector entry;
// a jump target is word-aligned.
module pipe_ctl_target
  import pipe_ctl_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        exc_req_i,
  input  logic [2:0]  exc_vec_i,
  input  logic [31:0] jmp_pc_i,
  output logic [31:0] target_o,
  output logic        is_exc_o
);

  always_comb begin
    is_exc_o = exc_req_i;
    if (exc_req_i) begin
      target_o = exc_target(VECTOR_BASE, exc_vec_i);
    end else begin
      target_o = {jmp_pc_i[31:2], 2'b00};
    end
  end

endmodule

// File: rtl/pipe_ctl.sv
// Central stall/flush/redirect sequencer for fetch -> issue -> execute -> memory.
// Define PIPE_CTL_PERF_EN to add stall-cycle and redirect counters.
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input logic       clk,
  input logic       Nrst,
  pipe_ctl_if.master bus
);

  localparam logic [CntWidth-1:0] FlushLoad = CntWidth'(FLUSH_DEPTH);

  pipe_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;

  logic        accept;
  logic        tgt_is_exc;
  logic [31:0] tgt_pc;
  logic        stall_fetch;
  logic        stall_issue;

  pipe_ctl_target #(
    .VECTOR_BASE(VECTOR_BASE)
  ) u_target (
    .exc_req_i(bus.exc_req),
    .exc_vec_i(bus.exc_vec),
    .jmp_pc_i (bus.jmp_pc),
    .target_o (tgt_pc),
    .is_exc_o (tgt_is_exc)
  );

  // Events arriving while memory is busy are dropped; the source must hold them.
  assign accept      = (bus.jmp_valid | bus.exc_req) & ~bus.mem_busy;
  assign stall_issue = bus.mem_busy;
  assign stall_fetch = bus.issue_outstall | bus.mem_busy | (state_q == StRedir);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;

    bus.stall_fetch    = stall_fetch;
    bus.stall_issue    = stall_issue;
    bus.stall_exec     = stall_issue;
    bus.redirect_valid = (state_q == StRedir);
    bus.redirect_pc    = redirect_pc_q;
    bus.exc_taken      = accept & tgt_is_exc;
    bus.flush_fetch    = accept | (state_q == StRedir);
    bus.flush_issue    = accept | (state_q != StRun);

    // A new event overrides any pending redirect or shadow, including a same-cycle ack.
    if (accept) begin
      state_d       = StRedir;
      redirect_pc_d = tgt_pc;
      cnt_d         = FlushLoad;
    end else begin
      unique case (state_q)
        StRun: ;
        StRedir: begin
          if (bus.fetch_ack) begin
            state_d = StShadow;
            cnt_d   = FlushLoad;
          end
        end
        StShadow: begin
          if (!stall_issue) begin
            if (cnt_q == CntWidth'(1)) begin
              state_d = StRun;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntWidth'(1);
            end
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q       <= StRun;
      cnt_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  cnt_legal_a: assert property (@(posedge clk) disable iff (!Nrst)
                                (state_q != StRun) |-> (cnt_q != '0));

`ifdef PIPE_CTL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_redir_q, perf_redir_d;

  always_comb begin
    perf_stall_d          = perf_stall_q + 32'(stall_fetch);
    perf_redir_d          = perf_redir_q + 32'(accept);
    bus.perf_stall_cycles = perf_stall_q;
    bus.perf_redirects    = perf_redir_q;
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_redir_q <= perf_redir_d;
      if (accept) begin
        $display("[pipe_ctl] redirect to %08h (%s)", tgt_pc, tgt_is_exc ? "EXC" : "JMP");
      end
    end
  end
`endif

endmodule
